// File: rtl/lcd_fetch_ctrl.sv
// rtl/lcd_fetch_ctrl.sv - frame fetch sequencer feeding the LCD pixel FIFO from a memory framebuffer
module lcd_fetch_ctrl #(
  parameter int FRAME_PIXELS = 76800,
  parameter int BURST_LEN    = 256,
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 16,
  parameter int PIX_BYTES    = 2,
  parameter int LEN_W        = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              frame_start,
  input  logic [ADDR_W-1:0] fb_base,
  input  logic              clr_err,
  output logic              busy,
  output logic              frame_done,
  output logic              err_ovf,
  output logic              err_late,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LEN_W-1:0]  mem_len,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              fifo_wr_en,
  output logic [DATA_W-1:0] fifo_wr_data,
  input  logic              fifo_wr_full,
  input  logic              fifo_almost_full
);

  localparam int REM_W = $clog2(FRAME_PIXELS + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SPACE = 2'd1;
  localparam logic [1:0] S_REQ   = 2'd2;
  localparam logic [1:0] S_DATA  = 2'd3;

  localparam logic [REM_W-1:0] FRAME_CNT = REM_W'(FRAME_PIXELS);
  localparam logic [LEN_W-1:0] BURST_CNT = LEN_W'(BURST_LEN);

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [REM_W-1:0]  r_remain;
  logic [LEN_W-1:0]  r_beats;
  logic              r_stop;
  logic              r_busy;
  logic              r_frame_done;
  logic              r_err_ovf;
  logic              r_err_late;
  logic              r_mem_req;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [LEN_W-1:0]  r_mem_len;

  logic              w_beat;
  logic              w_last;
  logic [LEN_W-1:0]  w_next_len;
  logic [ADDR_W-1:0] w_step;
  logic [REM_W-1:0]  w_remain_next;

  // Only beats that arrive while a burst is outstanding belong to the frame;
  // anything else is a stale beat from an aborted burst.
  assign w_beat        = mem_rvalid && (r_state == S_DATA);
  assign w_last        = w_beat && (r_beats == LEN_W'(1));
  assign w_next_len    = (int'(r_remain) >= BURST_LEN) ? BURST_CNT : LEN_W'(r_remain);
  assign w_step        = ADDR_W'(r_mem_len) * ADDR_W'(PIX_BYTES);
  assign w_remain_next = r_remain - REM_W'(r_mem_len);

  assign fifo_wr_en   = w_beat && !fifo_wr_full;
  assign fifo_wr_data = mem_rdata;

  assign busy       = r_busy;
  assign frame_done = r_frame_done;
  assign err_ovf    = r_err_ovf;
  assign err_late   = r_err_late;
  assign mem_req    = r_mem_req;
  assign mem_addr   = r_mem_addr;
  assign mem_len    = r_mem_len;

  // Frame sequencing: wait for FIFO room, request a burst, count its beats, advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_addr       <= '0;
      r_remain     <= '0;
      r_beats      <= '0;
      r_stop       <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_mem_req    <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_len    <= '0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (frame_start && enable) begin
            r_addr   <= fb_base;
            r_remain <= FRAME_CNT;
            r_busy   <= 1'b1;
            r_state  <= S_SPACE;
          end
        end
        S_SPACE: begin
          if (!enable) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (!fifo_almost_full) begin
            r_mem_req  <= 1'b1;
            r_mem_addr <= r_addr;
            r_mem_len  <= w_next_len;
            r_state    <= S_REQ;
          end
        end
        S_REQ: begin
          // A disable while a burst is in flight is remembered and honoured
          // once the burst has fully drained.
          if (!enable) begin
            r_stop <= 1'b1;
          end
          if (mem_gnt) begin
            r_mem_req <= 1'b0;
            r_beats   <= r_mem_len;
            r_state   <= S_DATA;
          end
        end
        S_DATA: begin
          if (!enable) begin
            r_stop <= 1'b1;
          end
          if (w_beat) begin
            r_beats <= r_beats - LEN_W'(1);
            if (w_last) begin
              r_addr   <= r_addr + w_step;
              r_remain <= w_remain_next;
              r_stop   <= 1'b0;
              if (w_remain_next == '0) begin
                r_frame_done <= 1'b1;
                r_busy       <= 1'b0;
                r_state      <= S_IDLE;
              end else if (r_stop || !enable) begin
                r_busy  <= 1'b0;
                r_state <= S_IDLE;
              end else begin
                r_state <= S_SPACE;
              end
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Sticky error flags; a new event in the same cycle as clr_err keeps the flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_ovf  <= 1'b0;
      r_err_late <= 1'b0;
    end else begin
      if (w_beat && fifo_wr_full) begin
        r_err_ovf <= 1'b1;
      end else if (clr_err) begin
        r_err_ovf <= 1'b0;
      end
      if (frame_start && r_busy) begin
        r_err_late <= 1'b1;
      end else if (clr_err) begin
        r_err_late <= 1'b0;
      end
    end
  end

endmodule
